// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I core.
// Owns the PC, talks req/ack to imem, buffers stalled responses, flushes on branch.
module if_fetch_stage #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_write,
   input  logic            if_idWrite,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [31:0]     if_id_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic            if_id_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_addr;
   logic [31:0]     hold_instr;
   logic [XLEN-1:0] hold_pc;
   logic            kill;
   logic [XLEN-1:0] req_next;
   logic [XLEN-1:0] hold_next;

   assign imem_req  = (state == REQ);
   assign imem_addr = req_addr;
   assign req_next  = req_addr + XLEN'(4);
   assign hold_next = hold_pc + XLEN'(4);

   // Fetch FSM, PC bookkeeping and IF/ID register, all advanced on one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         fetch_pc    <= XLEN'(RESET_PC);
         req_addr    <= XLEN'(RESET_PC);
         hold_instr  <= NOP_INSTR;
         hold_pc     <= '0;
         kill        <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state <= REQ;
               if (branch_taken) begin
                  fetch_pc    <= branch_target;
                  req_addr    <= branch_target;
                  if_id_instr <= NOP_INSTR;
                  if_id_pc    <= '0;
                  if_id_valid <= 1'b0;
               end else begin
                  req_addr <= fetch_pc;
               end
            end
            REQ: begin
               if (branch_taken) begin
                  if_id_instr <= NOP_INSTR;
                  if_id_pc    <= '0;
                  if_id_valid <= 1'b0;
                  fetch_pc    <= branch_target;
                  if (imem_ack) begin
                     kill     <= 1'b0;
                     req_addr <= branch_target;
                  end else begin
                     kill <= 1'b1;
                  end
               end else if (imem_ack) begin
                  if (kill) begin
                     kill     <= 1'b0;
                     req_addr <= fetch_pc;
                  end else if (if_idWrite) begin
                     if_id_instr <= imem_rdata[31:0];
                     if_id_pc    <= req_addr;
                     if_id_valid <= 1'b1;
                     if (pc_write) begin
                        fetch_pc <= req_next;
                        req_addr <= req_next;
                     end
                  end else begin
                     hold_instr <= imem_rdata[31:0];
                     hold_pc    <= req_addr;
                     state      <= HOLD;
                  end
               end else if (if_idWrite) begin
                  if_id_instr <= NOP_INSTR;
                  if_id_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (branch_taken) begin
                  if_id_instr <= NOP_INSTR;
                  if_id_pc    <= '0;
                  if_id_valid <= 1'b0;
                  fetch_pc    <= branch_target;
                  req_addr    <= branch_target;
                  state       <= REQ;
               end else if (if_idWrite) begin
                  if_id_instr <= hold_instr;
                  if_id_pc    <= hold_pc;
                  if_id_valid <= 1'b1;
                  fetch_pc    <= hold_next;
                  req_addr    <= hold_next;
                  state       <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios, then random
// hazard/ack/branch traffic against a transaction-level reference model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write, if_idWrite, branch_taken, imem_ack;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc;
   logic        if_id_valid;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_rdata, w_instr, w_pc;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0)
         return 32'h0050_0093;
      else if (a == 32'h4)
         return 32'h0010_0113;
      else
         return (a * 32'd3) ^ 32'h1234_0013;
   endfunction

   assign imem_rdata = mem_word(imem_addr);
   assign w_rdata    = mem_word(w_addr);

   if_fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .pc_write(pc_write), .if_idWrite(if_idWrite),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) wdut (
      .clk(clk), .rst_n(rst_n),
      .pc_write(1'b1), .if_idWrite(1'b1),
      .branch_taken(1'b0), .branch_target(32'h0),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(1'b1), .imem_rdata(w_rdata),
      .if_id_instr(w_instr), .if_id_pc(w_pc),
      .if_id_valid(w_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic v,
                             input logic [31:0] pc, input logic [31:0] ins);
      check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
      check({tag, ".pc"}, if_id_pc, pc);
      check({tag, ".instr"}, if_id_instr, ins);
   endtask

   task automatic check_req(input string tag, input logic r,
                            input logic [31:0] a);
      check({tag, ".req"}, 32'(imem_req), 32'(r));
      check({tag, ".addr"}, imem_addr, a);
   endtask

   // reference model: abstract fetch unit state, updated once per clock edge
   bit          m_idle, m_req, m_held, m_drop;
   logic [31:0] m_addr, m_next, m_hold_pc;
   logic        e_valid;
   logic [31:0] e_pc, e_instr;

   task automatic model_reset();
      m_idle = 1; m_req = 0; m_held = 0; m_drop = 0;
      m_addr = 0; m_next = 0; m_hold_pc = 0;
      e_valid = 0; e_pc = 0; e_instr = NOP;
   endtask

   task automatic model_edge();
      bit acc;
      acc = m_req && imem_ack;
      if (m_idle) begin
         m_idle = 0; m_req = 1; m_addr = m_next;
      end else if (branch_taken) begin
         e_valid = 0; e_pc = 0; e_instr = NOP;
         m_next = branch_target;
         if (m_held) begin
            m_held = 0; m_req = 1; m_addr = branch_target;
         end else if (acc) begin
            m_drop = 0; m_addr = branch_target;
         end else begin
            m_drop = 1;
         end
      end else if (m_held) begin
         if (if_idWrite) begin
            e_valid = 1; e_pc = m_hold_pc; e_instr = mem_word(m_hold_pc);
            m_next = m_hold_pc + 4; m_addr = m_next;
            m_held = 0; m_req = 1;
         end
      end else if (acc) begin
         if (m_drop) begin
            m_drop = 0; m_addr = m_next;
         end else if (if_idWrite) begin
            e_valid = 1; e_pc = m_addr; e_instr = mem_word(m_addr);
            if (pc_write) begin
               m_addr = m_addr + 4; m_next = m_addr;
            end
         end else begin
            m_held = 1; m_req = 0; m_hold_pc = m_addr;
         end
      end else if (if_idWrite) begin
         e_valid = 0; e_instr = NOP;
      end
   endtask

   initial begin
      rst_n = 0; pc_write = 1; if_idWrite = 1;
      branch_taken = 0; branch_target = 0; imem_ack = 0;
      step(); step();
      check_req("rst", 1'b0, 32'h0);
      check_ifid("rst", 1'b0, 32'h0, NOP);
      check("rst.w_addr", w_addr, 32'hFFFF_FFFC);

      rst_n = 1;
      step();
      check_req("rel", 1'b1, 32'h0);
      check("wrap.req", 32'(w_req), 32'h1);
      check("wrap.addr0", w_addr, 32'hFFFF_FFFC);
      step();
      check("wrap.addr1", w_addr, 32'h0);
      check("wrap.ifid_pc", w_pc, 32'hFFFF_FFFC);
      check("wrap.valid", 32'(w_valid), 32'h1);
      check_ifid("noack_bubble", 1'b0, 32'h0, NOP);

      // reset asserted in the middle of an outstanding request
      rst_n = 0;
      #1;
      check_req("midrst", 1'b0, 32'h0);
      check_ifid("midrst", 1'b0, 32'h0, NOP);
      step();
      rst_n = 1;
      step();
      check_req("rel2", 1'b1, 32'h0);

      // streaming
      imem_ack = 1;
      step();
      check_ifid("s0", 1'b1, 32'h0, 32'h0050_0093);
      check_req("s0", 1'b1, 32'h4);
      step();
      check_ifid("s1", 1'b1, 32'h4, 32'h0010_0113);
      check_req("s1", 1'b1, 32'h8);

      // stall with response for 0x8 arriving
      if_idWrite = 0; pc_write = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall", 1'b1, 32'h4, 32'h0010_0113);
         check("stall.req", 32'(imem_req), 32'h0);
      end
      if_idWrite = 1; pc_write = 1; imem_ack = 0;
      step();
      check_ifid("unstall", 1'b1, 32'h8, mem_word(32'h8));
      check_req("unstall", 1'b1, 32'hC);

      // slow memory: two bubbles then the word
      for (int i = 0; i < 2; i++) begin
         step();
         check_ifid("lat.bub", 1'b0, 32'h8, NOP);
         check_req("lat", 1'b1, 32'hC);
      end
      imem_ack = 1;
      step();
      check_ifid("lat.hit", 1'b1, 32'hC, mem_word(32'hC));
      check_req("lat.hit", 1'b1, 32'h10);

      // branch while 0x10 is in flight
      imem_ack = 0; branch_taken = 1; branch_target = 32'h100;
      step();
      check_ifid("br.flush", 1'b0, 32'h0, NOP);
      check_req("br.stable", 1'b1, 32'h10);
      branch_taken = 0;
      step();
      check_req("br.wait", 1'b1, 32'h10);
      imem_ack = 1;
      step();
      check_ifid("br.drop", 1'b0, 32'h0, NOP);
      check_req("br.redir", 1'b1, 32'h100);
      step();
      check_ifid("br.tgt", 1'b1, 32'h100, mem_word(32'h100));
      check_req("br.next", 1'b1, 32'h104);

      // random traffic against the reference model
      rst_n = 0; imem_ack = 0; branch_taken = 0;
      step();
      rst_n = 1;
      model_reset();
      for (int c = 0; c < 600; c++) begin
         imem_ack      = ($urandom_range(0, 2) != 0);
         if_idWrite    = ($urandom_range(0, 3) != 0);
         pc_write      = ($urandom_range(0, 4) != 0);
         branch_taken  = !m_idle && ($urandom_range(0, 9) == 0);
         branch_target = {16'h0, 14'($urandom), 2'b00};
         model_edge();
         step();
         check("rnd.req", 32'(imem_req), 32'(m_req));
         if (m_req)
            check("rnd.addr", imem_addr, m_addr);
         check_ifid("rnd", e_valid, e_pc, e_instr);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
